// File: rtl/wired_commit_pkg.sv
// rtl/wired_commit_pkg.sv - shared types and helpers for the in-order commit stage
package wired_commit_pkg;

  localparam int          ROB_LEN_DEFAULT    = 4;
  localparam logic [31:0] EXCP_ENTRY_DEFAULT = 32'h1C00_0000;

  typedef logic [ROB_LEN_DEFAULT-1:0] rob_rid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        wen;
  } rob_static_t;

  typedef struct packed {
    logic        excp;
    logic        need_jump;
    logic [31:0] jump_target;
    logic        uncached;
    logic        store_buffer;
  } rob_dynamic_t;

  typedef struct packed {
    logic [31:0] wdata;
  } rob_data_t;

  typedef struct packed {
    rob_static_t  sta;
    rob_dynamic_t dyn;
    rob_data_t    dat;
  } rob_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } commit_state_e;

  function automatic logic is_redirect(rob_entry_t e);
    return e.dyn.excp | e.dyn.need_jump | e.dyn.uncached;
  endfunction

  // Exceptions outrank uncached replay, which outranks a taken jump.
  function automatic logic [31:0] redirect_target(rob_entry_t e, logic [31:0] excp_entry);
    if (e.dyn.excp) return excp_entry;
    if (e.dyn.uncached) return e.sta.pc;
    return e.dyn.jump_target;
  endfunction

endpackage

// File: rtl/wired_commit.sv
// rtl/wired_commit.sv - in-order commit stage retiring up to two ROB entries per cycle
module wired_commit
  import wired_commit_pkg::*;
#(
  parameter int          ROB_LEN    = ROB_LEN_DEFAULT,
  parameter logic [31:0] EXCP_ENTRY = EXCP_ENTRY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              p_valid_i,
  output logic [1:0][ROB_LEN-1:0] c_rrrid_o,
  input  logic [1:0]              c_rob_valid_i,
  input  rob_entry_t [1:0]        c_rob_entry_i,
  output logic [1:0]              c_retire_o,
  output logic [1:0]              c_arf_we_o,
  output logic [1:0][4:0]         c_arf_waddr_o,
  output logic [1:0][31:0]        c_arf_wdata_o,
  output logic [1:0]              c_sb_commit_o,
  output logic                    c_flush_o,
  output logic                    c_redirect_o,
  output logic [31:0]             c_redirect_pc_o,
  output logic                    c_uncached_replay_o
);

  localparam int DEPTH = 1 << ROB_LEN;

  commit_state_e      state_q, state_d;
  logic [ROB_LEN-1:0] head_q;
  logic [ROB_LEN:0]   occ_q, occ_d;
  logic [ROB_LEN:0]   drain_q, drain_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               replay_q, replay_d;
  logic               redirect_q, redirect_d;

  logic [1:0]         retire;
  logic [1:0]         n_ret;
  logic [1:0]         n_disp;
  logic               fire;
  rob_entry_t         x_entry;

  // Slot1 may only follow a non-redirecting slot0, and one store-buffer commit per cycle pair.
  function automatic logic [1:0] run_retire(logic [1:0] v, rob_entry_t e0, rob_entry_t e1);
    logic r0, r1;
    r0 = v[0];
    r1 = r0 & v[1] & ~is_redirect(e0) & ~(e0.dyn.store_buffer & e1.dyn.store_buffer);
    return {r1, r0};
  endfunction

  always_comb begin
    retire        = 2'b00;
    c_arf_we_o    = 2'b00;
    c_sb_commit_o = 2'b00;
    fire          = 1'b0;
    x_entry       = c_rob_entry_i[0];
    if (state_q == ST_RUN) begin
      retire = run_retire(c_rob_valid_i, c_rob_entry_i[0], c_rob_entry_i[1]);
      for (int i = 0; i < 2; i++) begin
        c_arf_we_o[i]    = retire[i] & c_rob_entry_i[i].sta.wen
                           & ~c_rob_entry_i[i].dyn.excp & ~c_rob_entry_i[i].dyn.uncached;
        c_sb_commit_o[i] = retire[i] & c_rob_entry_i[i].dyn.store_buffer
                           & ~c_rob_entry_i[i].dyn.excp & ~c_rob_entry_i[i].dyn.uncached;
      end
      if (retire[0] & is_redirect(c_rob_entry_i[0])) begin
        fire    = 1'b1;
        x_entry = c_rob_entry_i[0];
      end else if (retire[1] & is_redirect(c_rob_entry_i[1])) begin
        fire    = 1'b1;
        x_entry = c_rob_entry_i[1];
      end
    end else begin
      retire = {drain_q >= (ROB_LEN+1)'(2), drain_q >= (ROB_LEN+1)'(1)};
    end
  end

  assign n_ret  = {1'b0, retire[0]} + {1'b0, retire[1]};
  assign n_disp = {1'b0, p_valid_i[0]} + {1'b0, p_valid_i[1]};
  assign occ_d  = occ_q + (ROB_LEN+1)'(n_disp) - (ROB_LEN+1)'(n_ret);

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    redirect_pc_d = redirect_pc_q;
    replay_d      = replay_q;
    redirect_d    = 1'b0;
    if (state_q == ST_RUN) begin
      // Everything still in the ROB after this cycle, including same-cycle dispatches, is drained.
      if (fire) begin
        state_d       = ST_DRAIN;
        drain_d       = occ_d;
        redirect_d    = 1'b1;
        redirect_pc_d = redirect_target(x_entry, EXCP_ENTRY);
        replay_d      = x_entry.dyn.uncached & ~x_entry.dyn.excp;
      end
    end else begin
      drain_d = drain_q - (ROB_LEN+1)'(n_ret);
      if (drain_q <= (ROB_LEN+1)'(2)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      head_q        <= '0;
      occ_q         <= '0;
      drain_q       <= '0;
      redirect_pc_q <= '0;
      replay_q      <= 1'b0;
      redirect_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_q + ROB_LEN'(n_ret);
      occ_q         <= occ_d;
      drain_q       <= drain_d;
      redirect_pc_q <= redirect_pc_d;
      replay_q      <= replay_d;
      redirect_q    <= redirect_d;
    end
  end

  assign c_rrrid_o[0]        = head_q;
  assign c_rrrid_o[1]        = head_q + ROB_LEN'(1);
  assign c_retire_o          = retire;
  assign c_arf_waddr_o[0]    = c_rob_entry_i[0].sta.wreg;
  assign c_arf_waddr_o[1]    = c_rob_entry_i[1].sta.wreg;
  assign c_arf_wdata_o[0]    = c_rob_entry_i[0].dat.wdata;
  assign c_arf_wdata_o[1]    = c_rob_entry_i[1].dat.wdata;
  assign c_flush_o           = (state_q == ST_DRAIN);
  assign c_redirect_o        = redirect_q;
  assign c_redirect_pc_o     = redirect_pc_q;
  assign c_uncached_replay_o = redirect_q & replay_q;

  a_no_dispatch_in_drain : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) |-> (p_valid_i == 2'b00));

  a_occ_in_range : assert property (@(posedge clk) disable iff (rst)
    ((int'(occ_q) + int'(n_disp) >= int'(n_ret)) &&
     (int'(occ_q) + int'(n_disp) - int'(n_ret) <= DEPTH)));

endmodule

// File: tb/tb_wired_commit.sv
// tb/tb_wired_commit.sv - directed and randomized checks of wired_commit against a queue-based ROB model
module tb_wired_commit;
  import wired_commit_pkg::*;

  localparam int RL    = ROB_LEN_DEFAULT;
  localparam int DEPTH = 1 << RL;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         p_valid;
  logic [1:0][RL-1:0] rrrid;
  logic [1:0]         rob_valid;
  rob_entry_t [1:0]   ent;
  logic [1:0]         retire, arf_we, sb_commit;
  logic [1:0][4:0]    waddr;
  logic [1:0][31:0]   wdata;
  logic               flush, redirect, replay;
  logic [31:0]        redirect_pc;

  wired_commit dut (
    .clk                 (clk),
    .rst                 (rst),
    .p_valid_i           (p_valid),
    .c_rrrid_o           (rrrid),
    .c_rob_valid_i       (rob_valid),
    .c_rob_entry_i       (ent),
    .c_retire_o          (retire),
    .c_arf_we_o          (arf_we),
    .c_arf_waddr_o       (waddr),
    .c_arf_wdata_o       (wdata),
    .c_sb_commit_o       (sb_commit),
    .c_flush_o           (flush),
    .c_redirect_o        (redirect),
    .c_redirect_pc_o     (redirect_pc),
    .c_uncached_replay_o (replay)
  );

  always #5 clk = ~clk;

  typedef struct {
    rob_entry_t e;
    bit         done;
  } slot_t;

  slot_t       rob[$];
  rob_entry_t  stage[$];
  int          head;
  bit          draining, first, hold_replay;
  logic [31:0] hold_pc;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit redir_class(rob_entry_t e);
    return e.dyn.excp || e.dyn.need_jump || e.dyn.uncached;
  endfunction

  function automatic rob_entry_t mk(logic [31:0] pc, logic [4:0] wreg, logic [31:0] d);
    rob_entry_t e;
    e           = '0;
    e.sta.pc    = pc;
    e.sta.wreg  = wreg;
    e.sta.wen   = 1'b1;
    e.dat.wdata = d;
    return e;
  endfunction

  function automatic rob_entry_t rnd_entry();
    rob_entry_t e;
    e.sta.pc           = $urandom;
    e.sta.wreg         = 5'($urandom);
    e.sta.wen          = 1'($urandom);
    e.dyn.excp         = ($urandom_range(0, 19) == 0);
    e.dyn.need_jump    = ($urandom_range(0, 15) == 0);
    e.dyn.jump_target  = $urandom;
    e.dyn.uncached     = ($urandom_range(0, 23) == 0);
    e.dyn.store_buffer = ($urandom_range(0, 3) == 0);
    e.dat.wdata        = $urandom;
    return e;
  endfunction

  // One clock: drive from the model, compare outputs, then advance the model.
  task automatic cycle(input int ndisp);
    logic [1:0]    er, ewe, esb;
    logic [RL-1:0] h0, h1;
    int            x, k, size0;
    slot_t         s;
    @(negedge clk);
    rst     = 1'b0;
    p_valid = (ndisp == 2) ? 2'b11 : (ndisp == 1) ? 2'b01 : 2'b00;
    size0   = rob.size();
    for (int i = 0; i < 2; i++) begin
      rob_valid[i] = (size0 > i) && rob[i].done;
      if (size0 > i) ent[i] = rob[i].e;
      else ent[i] = '0;
    end
    er = 2'b00; ewe = 2'b00; esb = 2'b00; x = -1;
    if (draining) begin
      k  = (size0 < 2) ? size0 : 2;
      er = (k == 2) ? 2'b11 : (k == 1) ? 2'b01 : 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (size0 <= i || !rob[i].done) break;
        if (i == 1 && rob[0].e.dyn.store_buffer && rob[1].e.dyn.store_buffer) break;
        er[i]  = 1'b1;
        ewe[i] = rob[i].e.sta.wen && !rob[i].e.dyn.excp && !rob[i].e.dyn.uncached;
        esb[i] = rob[i].e.dyn.store_buffer && !rob[i].e.dyn.excp && !rob[i].e.dyn.uncached;
        if (redir_class(rob[i].e)) begin
          x = i;
          break;
        end
      end
    end
    h0 = RL'(head);
    h1 = RL'(head + 1);
    #1;
    check("rrrid", 64'(rrrid), 64'({h1, h0}));
    check("retire", 64'(retire), 64'(er));
    check("arf_we", 64'(arf_we), 64'(ewe));
    check("sb_commit", 64'(sb_commit), 64'(esb));
    check("flush", 64'(flush), 64'(draining));
    check("redirect", 64'(redirect), 64'(draining && first));
    for (int i = 0; i < 2; i++) begin
      if (ewe[i]) begin
        check("arf_waddr", 64'(waddr[i]), 64'(rob[i].e.sta.wreg));
        check("arf_wdata", 64'(wdata[i]), 64'(rob[i].e.dat.wdata));
      end
    end
    if (draining) begin
      check("redirect_pc", 64'(redirect_pc), 64'(hold_pc));
      check("replay", 64'(replay), 64'(first && hold_replay));
    end else begin
      check("replay_idle", 64'(replay), 64'd0);
    end
    @(posedge clk);
    k = int'(er[0]) + int'(er[1]);
    for (int i = 0; i < k; i++) void'(rob.pop_front());
    head = (head + k) % DEPTH;
    for (int i = 0; i < ndisp; i++) begin
      s.e    = stage.pop_front();
      s.done = 1'b0;
      rob.push_back(s);
    end
    if (draining) begin
      first = 1'b0;
      if (size0 <= 2) draining = 1'b0;
    end else if (x >= 0) begin
      draining    = 1'b1;
      first       = 1'b1;
      hold_replay = rob_entry_uncached_only(ent[x]);
      if (ent[x].dyn.excp) hold_pc = 32'h1C00_0000;
      else if (ent[x].dyn.uncached) hold_pc = ent[x].sta.pc;
      else hold_pc = ent[x].dyn.jump_target;
    end
  endtask

  function automatic bit rob_entry_uncached_only(rob_entry_t e);
    return e.dyn.uncached && !e.dyn.excp;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    p_valid   = 2'b00;
    rob_valid = 2'b00;
    ent       = '0;
    @(posedge clk);
    #1;
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_redirect", 64'(redirect), 64'd0);
    check("rst_rrrid", 64'(rrrid), 64'h10);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_we_sb", 64'({arf_we, sb_commit}), 64'd0);
    check("rst_replay", 64'(replay), 64'd0);
    @(posedge clk);
    rob.delete();
    stage.delete();
    head     = 0;
    draining = 1'b0;
    first    = 1'b0;
  endtask

  initial begin
    rob_entry_t t;
    rst = 1'b1; p_valid = 2'b00; rob_valid = 2'b00; ent = '0;
    head = 0; draining = 1'b0; first = 1'b0; hold_replay = 1'b0; hold_pc = '0;
    do_reset();

    // Dual retire with ARF writes, then same-wreg pair.
    stage.push_back(mk(32'h100, 5'd3, 32'h11));
    stage.push_back(mk(32'h104, 5'd4, 32'h22));
    cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0); cycle(0);
    stage.push_back(mk(32'h108, 5'd7, 32'h33));
    stage.push_back(mk(32'h10C, 5'd7, 32'h44));
    cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0);

    // Head+1 not yet complete.
    stage.push_back(mk(32'h110, 5'd5, 32'h55));
    stage.push_back(mk(32'h114, 5'd6, 32'h66));
    cycle(2); rob[0].done = 1; cycle(0); rob[0].done = 1; cycle(0);

    // Jump at head with five younger entries behind it.
    t = mk(32'h120, 5'd8, 32'h77); t.dyn.need_jump = 1; t.dyn.jump_target = 32'h1C00_0100;
    stage.push_back(t);
    for (int i = 0; i < 5; i++) stage.push_back(mk(32'h124 + 4 * i, 5'(10 + i), 32'(i)));
    cycle(2); cycle(2); cycle(2);
    rob[0].done = 1; rob[1].done = 1;
    cycle(0); cycle(0); cycle(0); cycle(0); cycle(0);

    // Exception at head, nothing behind it.
    t = mk(32'h200, 5'd9, 32'h99); t.dyn.excp = 1;
    stage.push_back(t); cycle(1); rob[0].done = 1; cycle(0); cycle(0); cycle(0);

    // Adjacent store-buffer entries, then uncached store.
    t = mk(32'h300, 5'd0, 32'h0); t.sta.wen = 0; t.dyn.store_buffer = 1;
    stage.push_back(t); stage.push_back(t);
    cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0); cycle(0);
    t = mk(32'h80, 5'd12, 32'hAB); t.dyn.uncached = 1; t.dyn.store_buffer = 1;
    stage.push_back(t); cycle(1); rob[0].done = 1; cycle(0); cycle(0); cycle(0);

    // Redirect in slot1 behind a normal instruction.
    stage.push_back(mk(32'h400, 5'd13, 32'hCD));
    t = mk(32'h404, 5'd14, 32'hEF); t.dyn.need_jump = 1; t.dyn.jump_target = 32'h500;
    stage.push_back(t);
    cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0); cycle(0); cycle(0);

    // Head wrap-around.
    do_reset();
    for (int n = 0; n < 7; n++) begin
      stage.push_back(mk(32'h600, 5'd1, 32'(n))); stage.push_back(mk(32'h604, 5'd2, 32'(n)));
      cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0);
    end
    stage.push_back(mk(32'h608, 5'd3, 32'h1)); cycle(1); rob[0].done = 1; cycle(0);
    stage.push_back(mk(32'h60C, 5'd4, 32'h2)); stage.push_back(mk(32'h610, 5'd5, 32'h3));
    cycle(2); rob[0].done = 1; rob[1].done = 1; cycle(0); cycle(0);

    // Reset in the middle of a drain.
    t = mk(32'h700, 5'd6, 32'h4); t.dyn.excp = 1;
    stage.push_back(t);
    for (int i = 0; i < 5; i++) stage.push_back(mk(32'h704, 5'd7, 32'h5));
    cycle(2); cycle(2); cycle(2); rob[0].done = 1; cycle(0); cycle(0);
    do_reset();
    stage.push_back(mk(32'h800, 5'd8, 32'h6)); cycle(1); rob[0].done = 1; cycle(0); cycle(0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int nd;
      if (!draining) begin
        foreach (rob[i]) if (!rob[i].done && $urandom_range(0, 2) == 0) rob[i].done = 1;
      end
      nd = draining ? 0 : int'($urandom_range(0, 2));
      if (rob.size() + nd > DEPTH) nd = DEPTH - rob.size();
      for (int i = 0; i < nd; i++) stage.push_back(rnd_entry());
      cycle(nd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
